// File: rtl/ravenoc_edge_sink_if.sv
// Router <-> edge-sink flit link.
// The router drives recv_* and reads recv_ready. The sink drives recv_ready
// and the (always idle) send_* egress path.
interface ravenoc_edge_sink_if #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VIRT_CHN = 2
);
  localparam int VCW = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

  logic                  recv_valid;
  logic [VCW-1:0]        recv_vc_id;
  logic [FLIT_WIDTH-1:0] recv_fdata;
  logic [N_VIRT_CHN-1:0] recv_ready;
  logic                  send_valid;
  logic [FLIT_WIDTH-1:0] send_fdata;

  modport master (
    output recv_valid, recv_vc_id, recv_fdata,
    input  recv_ready, send_valid, send_fdata
  );

  modport slave (
    input  recv_valid, recv_vc_id, recv_fdata,
    output recv_ready, send_valid, send_fdata
  );
endinterface

// File: rtl/ravenoc_edge_sink.sv
// Terminates an unused border-router port.
// SINK_MODE=0: passive tie-off, never ready.
// SINK_MODE=1: drains flits per VC, checks framing, counts drops and raises a
// sticky irq.
// Optional macro RAVENOC_EDGE_SINK_HDR_CAP_EN adds first_hdr/first_hdr_vc, which
// capture the first head flit accepted while irq is low.

// Per-VC framing checker and saturating drop counter.
module ravenoc_edge_sink_vc #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_noc,
  input  logic                 arst_noc_n,
  input  logic                 acc,
  input  logic [1:0]           ftype,
  input  logic                 clr,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] cnt
);
  localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

  typedef enum logic {IDLE, IN_PKT} st_t;
  st_t  st, st_nxt;
  logic err_set;

  // Next framing state and protocol-error detect for the current flit type
  always_comb begin
    st_nxt  = st;
    err_set = 1'b0;
    unique case (ftype)
      HEAD: begin st_nxt = IN_PKT; err_set = (st == IN_PKT); end
      HT:   begin st_nxt = IDLE;   err_set = (st == IN_PKT); end
      BODY: begin                  err_set = (st == IDLE);   end
      TAIL: begin st_nxt = IDLE;   err_set = (st == IDLE);   end
    endcase
  end

  // State, sticky error and counter; a set in the irq_clr cycle wins over the clear
  always_ff @(posedge clk_noc or negedge arst_noc_n) begin
    if (!arst_noc_n) begin
      st  <= IDLE;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      if (acc) st <= st_nxt;
      if (acc && err_set) err <= 1'b1;
      else if (clr)       err <= 1'b0;
      if (acc)      cnt <= clr ? CNT_WIDTH'(1) : ((&cnt) ? cnt : cnt + 1'b1);
      else if (clr) cnt <= '0;
    end
  end
endmodule

module ravenoc_edge_sink #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VIRT_CHN = 2,
  parameter int SINK_MODE  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk_noc,
  input  logic                             arst_noc_n,
  ravenoc_edge_sink_if.slave               rif,
  input  logic                             irq_clr,
  output logic                             irq,
  output logic [N_VIRT_CHN-1:0]            err_proto,
  output logic [N_VIRT_CHN*CNT_WIDTH-1:0]  drop_cnt
`ifdef RAVENOC_EDGE_SINK_HDR_CAP_EN
  ,
  output logic [FLIT_WIDTH-1:0]            first_hdr,
  output logic [((N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1)-1:0] first_hdr_vc
`endif
);
  localparam int VCW = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

  assign rif.send_valid = 1'b0;
  assign rif.send_fdata = '0;

  if (SINK_MODE == 0) begin : g_tie
    assign rif.recv_ready = '0;
    assign irq            = 1'b0;
    assign err_proto      = '0;
    assign drop_cnt       = '0;
`ifdef RAVENOC_EDGE_SINK_HDR_CAP_EN
    assign first_hdr      = '0;
    assign first_hdr_vc   = '0;
`endif
  end else begin : g_drain
    logic [N_VIRT_CHN-1:0] rdy;
    logic [1:0]            ftype;
    logic                  vc_ok;
    logic                  acc;

    assign ftype = rif.recv_fdata[FLIT_WIDTH-1 -: 2];
    // Out-of-range VC ids are dropped silently: no count, no state change
    assign vc_ok = (32'(rif.recv_vc_id) < N_VIRT_CHN);
    assign acc   = rif.recv_valid && vc_ok && rdy[rif.recv_vc_id];
    assign rif.recv_ready = rdy;

    // Ready is registered so it rises on the first edge after reset release
    always_ff @(posedge clk_noc or negedge arst_noc_n) begin
      if (!arst_noc_n) rdy <= '0;
      else             rdy <= '1;
    end

    // Sticky irq: every accepted flit sets it (a framing error implies one)
    always_ff @(posedge clk_noc or negedge arst_noc_n) begin
      if (!arst_noc_n)  irq <= 1'b0;
      else if (acc)     irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end

    for (genvar i = 0; i < N_VIRT_CHN; i++) begin : g_vc
      ravenoc_edge_sink_vc #(.CNT_WIDTH(CNT_WIDTH)) u_vc (
        .clk_noc    (clk_noc),
        .arst_noc_n (arst_noc_n),
        .acc        (acc && (rif.recv_vc_id == VCW'(i))),
        .ftype      (ftype),
        .clr        (irq_clr),
        .err        (err_proto[i]),
        .cnt        (drop_cnt[i*CNT_WIDTH +: CNT_WIDTH])
      );
    end

`ifdef RAVENOC_EDGE_SINK_HDR_CAP_EN
    // Capture the first head seen with irq low; a head in the clear cycle is kept
    always_ff @(posedge clk_noc or negedge arst_noc_n) begin
      if (!arst_noc_n) begin
        first_hdr    <= '0;
        first_hdr_vc <= '0;
      end else if (acc && (ftype == 2'b00 || ftype == 2'b11) && (!irq || irq_clr)) begin
        first_hdr    <= rif.recv_fdata;
        first_hdr_vc <= rif.recv_vc_id;
      end else if (irq_clr) begin
        first_hdr    <= '0;
        first_hdr_vc <= '0;
      end
    end
`endif
  end
endmodule

// File: tb/tb_ravenoc_edge_sink.sv
module tb_ravenoc_edge_sink;
  localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v = 1'b0;
  logic [0:0]  vc = '0;
  logic [33:0] fd = '0;
  logic        clr = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // DUT 0: default DRAIN, DUT 1: DRAIN with 4-bit counters, DUT 2: TIEOFF
  ravenoc_edge_sink_if #(.FLIT_WIDTH(34), .N_VIRT_CHN(2)) if0 ();
  ravenoc_edge_sink_if #(.FLIT_WIDTH(34), .N_VIRT_CHN(2)) if1 ();
  ravenoc_edge_sink_if #(.FLIT_WIDTH(34), .N_VIRT_CHN(2)) if2 ();

  assign if0.recv_valid = v; assign if0.recv_vc_id = vc; assign if0.recv_fdata = fd;
  assign if1.recv_valid = v; assign if1.recv_vc_id = vc; assign if1.recv_fdata = fd;
  assign if2.recv_valid = v; assign if2.recv_vc_id = vc; assign if2.recv_fdata = fd;

  logic        irq0, irq1, irq2;
  logic [1:0]  err0, err1, err2;
  logic [31:0] cnt0, cnt2;
  logic [7:0]  cnt1;
  logic [33:0] hdr0, hdr1, hdr2;
  logic [0:0]  hvc0, hvc1, hvc2;

  ravenoc_edge_sink #(.FLIT_WIDTH(34), .N_VIRT_CHN(2), .SINK_MODE(1), .CNT_WIDTH(16)) u_main (
    .clk_noc(clk), .arst_noc_n(rst_n), .rif(if0), .irq_clr(clr),
    .irq(irq0), .err_proto(err0), .drop_cnt(cnt0)
`ifdef RAVENOC_EDGE_SINK_HDR_CAP_EN
    , .first_hdr(hdr0), .first_hdr_vc(hvc0)
`endif
  );
  ravenoc_edge_sink #(.FLIT_WIDTH(34), .N_VIRT_CHN(2), .SINK_MODE(1), .CNT_WIDTH(4)) u_sat (
    .clk_noc(clk), .arst_noc_n(rst_n), .rif(if1), .irq_clr(clr),
    .irq(irq1), .err_proto(err1), .drop_cnt(cnt1)
`ifdef RAVENOC_EDGE_SINK_HDR_CAP_EN
    , .first_hdr(hdr1), .first_hdr_vc(hvc1)
`endif
  );
  ravenoc_edge_sink #(.FLIT_WIDTH(34), .N_VIRT_CHN(2), .SINK_MODE(0), .CNT_WIDTH(16)) u_tie (
    .clk_noc(clk), .arst_noc_n(rst_n), .rif(if2), .irq_clr(clr),
    .irq(irq2), .err_proto(err2), .drop_cnt(cnt2)
`ifdef RAVENOC_EDGE_SINK_HDR_CAP_EN
    , .first_hdr(hdr2), .first_hdr_vc(hvc2)
`endif
  );

`ifndef RAVENOC_EDGE_SINK_HDR_CAP_EN
  assign hdr0 = '0; assign hvc0 = '0; assign hdr1 = '0; assign hvc1 = '0;
  assign hdr2 = '0; assign hvc2 = '0;
`endif

  // Expected-state model, index d: 0 = main (16-bit), 1 = sat (4-bit)
  typedef struct {
    logic        irq [2];
    logic [1:0]  err [2];
    int          c   [2][2];
    logic [33:0] hdr;
    logic [0:0]  hvc;
  } exp_t;

  exp_t m;
  bit   m_st [2][2];
  exp_t sbq [$];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m.irq[d] = 1'b0; m.err[d] = 2'b00;
      for (int c = 0; c < 2; c++) begin m.c[d][c] = 0; m_st[d][c] = 1'b0; end
    end
    m.hdr = '0; m.hvc = '0;
  endtask

  task automatic model_step(input bit vv, input bit vcc, input logic [1:0] t,
                            input logic [33:0] f, input bit cc);
    int  lim;
    bit  es;
    if (vv && (t == HEAD || t == HT) && (!m.irq[0] || cc)) begin
      m.hdr = f; m.hvc = vcc;
    end else if (cc) begin
      m.hdr = '0; m.hvc = '0;
    end
    for (int d = 0; d < 2; d++) begin
      lim = (d == 0) ? 65535 : 15;
      for (int c = 0; c < 2; c++) begin
        if (vv && vcc == c[0]) begin
          es = m_st[d][c] ? (t == HEAD || t == HT) : (t == BODY || t == TAIL);
          if (t == HEAD) m_st[d][c] = 1'b1;
          else if (t != BODY) m_st[d][c] = 1'b0;
          m.c[d][c] = cc ? 1 : ((m.c[d][c] < lim) ? m.c[d][c] + 1 : lim);
          if (es) m.err[d][c] = 1'b1;
          else if (cc) m.err[d][c] = 1'b0;
        end else if (cc) begin
          m.c[d][c] = 0; m.err[d][c] = 1'b0;
        end
      end
      if (vv) m.irq[d] = 1'b1;
      else if (cc) m.irq[d] = 1'b0;
    end
  endtask

  task automatic check_tie();
    chk("tie_ready", if2.recv_ready, 2'b00);
    chk("tie_irq", irq2, 1'b0);
    chk("tie_err", err2, 2'b00);
    chk("tie_cnt", cnt2, 32'd0);
    chk("send_valid", {if0.send_valid, if1.send_valid, if2.send_valid}, 3'b000);
    chk("send_fdata", if0.send_fdata | if2.send_fdata, 34'd0);
  endtask

  // Drive one cycle of stimulus, record the expectation, compare after the edge
  task automatic step(input bit vv, input bit vcc, input logic [1:0] t,
                      input logic [31:0] pl, input bit cc);
    exp_t e;
    v = vv; vc = vcc; fd = {t, pl}; clr = cc;
    model_step(vv, vcc, t, {t, pl}, cc);
    sbq.push_back(m);
    @(posedge clk); #1;
    v = 1'b0; clr = 1'b0;
    e = sbq.pop_front();
    chk("main_ready", if0.recv_ready, 2'b11);
    chk("main_irq", irq0, e.irq[0]);
    chk("main_err", err0, e.err[0]);
    chk("main_cnt0", cnt0[15:0], e.c[0][0]);
    chk("main_cnt1", cnt0[31:16], e.c[0][1]);
    chk("sat_irq", irq1, e.irq[1]);
    chk("sat_err", err1, e.err[1]);
    chk("sat_cnt0", cnt1[3:0], e.c[1][0]);
    chk("sat_cnt1", cnt1[7:4], e.c[1][1]);
`ifdef RAVENOC_EDGE_SINK_HDR_CAP_EN
    chk("first_hdr", hdr0, e.hdr);
    chk("first_hdr_vc", hvc0, e.hvc);
`endif
    check_tie();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset state
    #1;
    chk("rst_ready", if0.recv_ready, 2'b00);
    chk("rst_irq", irq0, 1'b0);
    chk("rst_cnt", cnt0, 32'd0);
    chk("rst_err", err0, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_ready_pre", if0.recv_ready, 2'b00);
    @(posedge clk); #1;
    chk("rel_ready", if0.recv_ready, 2'b11);
    chk("rel_irq", irq0, 1'b0);
    chk("rel_cnt", cnt0, 32'd0);
    check_tie();

    // Clean packet on VC1
    step(1, 1, HEAD, 32'h11, 0);
    chk("t2_irq_after_head", irq0, 1'b1);
    step(1, 1, BODY, 32'h12, 0);
    step(1, 1, BODY, 32'h13, 0);
    step(1, 1, TAIL, 32'h14, 0);
    chk("t2_cnt_vc1", cnt0[31:16], 16'd4);
    chk("t2_cnt_vc0", cnt0[15:0], 16'd0);
    chk("t2_err", err0, 2'b00);

    // Orphan TAIL on VC0, then clear
    step(1, 0, TAIL, 32'h21, 0);
    chk("t3_err", err0, 2'b01);
    chk("t3_cnt_vc0", cnt0[15:0], 16'd1);
    step(0, 0, HEAD, 32'h0, 1);
    chk("t3_clr", {irq0, err0, cnt0}, 35'd0);

    // Accepted flit in the clear cycle: the set wins
    step(1, 1, HEAD, 32'h31, 0);
    step(1, 0, HT, 32'h32, 1);
    chk("t5_cnt", cnt0, 32'h0000_0001);
    chk("t5_irq", irq0, 1'b1);

    // IN_PKT + HEAD is an error and restarts the packet; then IN_PKT + HT
    step(1, 1, HEAD, 32'h33, 0);
    step(1, 1, HT, 32'h34, 0);
    step(1, 1, BODY, 32'h35, 0);

    // Header capture sequence
    step(0, 0, HEAD, 32'h0, 1);
    step(1, 1, HEAD, 32'h1234, 0);
    step(1, 0, HEAD, 32'h5678, 0);
`ifdef RAVENOC_EDGE_SINK_HDR_CAP_EN
    chk("t7_hdr", hdr0, {HEAD, 32'h1234});
    chk("t7_hvc", hvc0, 1'b1);
`endif
    step(1, 1, TAIL, 32'h0, 0);
    step(1, 0, TAIL, 32'h0, 0);

    // Saturation: 20 single-flit packets on VC0 after a clear
    step(0, 0, HEAD, 32'h0, 1);
    for (int i = 0; i < 20; i++) step(1, 0, HT, 32'(i), 0);
    chk("t4_sat_cnt", cnt1[3:0], 4'hF);
    chk("t4_sat_err", err1, 2'b00);
    chk("t4_main_cnt", cnt0[15:0], 16'd20);
    step(0, 0, HT, 32'h0, 0);

    // Reset mid-packet: async clear, then TAIL on that VC is a framing error
    step(1, 0, HEAD, 32'h41, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ready", if0.recv_ready, 2'b00);
    chk("mid_rst_status", {irq0, err0, cnt0}, 35'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 0, TAIL, 32'h42, 0);
    chk("mid_rst_tail_err", err0, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ravenoc_edge_sink.md
Name: ravenoc_edge_sink

Overview:
Parametrised successor to the mesh-edge tie-off. It terminates an unconnected router port (N/S/W/E on border routers) in one of two modes. In TIEOFF mode it is passive and never accepts flits. In DRAIN mode it accepts and discards misrouted flits per virtual channel, tracks packet framing, counts drops, and raises a sticky IRQ so software can detect routing faults. One instance sits on each unused border port of the NoC top.

Parameters:
FLIT_WIDTH, 34, total flit width; the 2 MSBs are the flit type.
N_VIRT_CHN, 2, number of virtual channels; must be >= 1.
SINK_MODE, 1, 0 = TIEOFF (legacy behaviour), 1 = DRAIN.
CNT_WIDTH, 16, width of each per-VC drop counter.

Ports:
clk_noc  in  1  NoC clock
arst_noc_n  in  1  asynchronous active-low reset
recv_valid  in  1  incoming flit valid
recv_vc_id  in  $clog2(N_VIRT_CHN) (min 1)  VC of the incoming flit
recv_fdata  in  FLIT_WIDTH  incoming flit
recv_ready  out  N_VIRT_CHN  per-VC ready back to the router
send_valid  out  1  egress valid toward the router; always 0
send_fdata  out  FLIT_WIDTH  egress data; always 0
irq_clr  in  1  single-cycle pulse; clears irq, err_proto and all counters
irq  out  1  sticky: a flit was dropped or a framing error occurred
err_proto  out  N_VIRT_CHN  sticky per-VC framing error
drop_cnt  out  N_VIRT_CHN*CNT_WIDTH  per-VC dropped-flit count; VC0 in the LSBs

Behaviour:
- Reset: every output is 0; every VC state is IDLE; counters are 0.
- Flit type = recv_fdata[FLIT_WIDTH-1 -: 2]: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
- TIEOFF (SINK_MODE=0):
  - recv_ready = 0 and irq = 0 permanently.
  - No state is kept; the counters and err_proto stay 0.
- DRAIN (SINK_MODE=1):
  - recv_ready = all-ones, registered, and asserted from the first clock edge after reset release.
  - A flit is accepted when recv_valid && recv_ready[recv_vc_id].
  - recv_vc_id >= N_VIRT_CHN: the flit is ignored, neither counted nor changing state.
- Per-VC framing FSM, 2 states:
  - IDLE + HEAD -> IN_PKT.
  - IDLE + HEAD_TAIL -> IDLE.
  - IDLE + BODY or TAIL -> IDLE, and err_proto[vc] is set.
  - IN_PKT + BODY -> IN_PKT.
  - IN_PKT + TAIL -> IDLE.
  - IN_PKT + HEAD or HEAD_TAIL -> err_proto[vc] is set, and the flit starts a new packet: the next state is IN_PKT for HEAD, IDLE for HEAD_TAIL.
- Every accepted flit increments drop_cnt[vc] by 1. The counter saturates at 2^CNT_WIDTH-1 and never wraps.
- irq is set on the cycle after any accepted flit or any err_proto set.
- irq_clr:
  - On the next edge it zeroes irq, err_proto and drop_cnt.
  - It does not reset the FSM state.
  - If an accepted flit arrives in the same cycle as irq_clr, the set wins: the counter becomes 1 and irq=1 in the following cycle.
- All status updates become visible 1 cycle after acceptance; there is no combinational path from recv_* to any output.
- Reset asserted mid-packet: everything returns to its reset values immediately (asynchronous). The next TAIL on that VC is a framing error.

Optional Feature:
Macro RAVENOC_EDGE_SINK_HDR_CAP_EN.
- Defined: adds output first_hdr (FLIT_WIDTH) and output first_hdr_vc ($clog2(N_VIRT_CHN), min 1).
  - These latch the first HEAD or HEAD_TAIL flit accepted while irq=0.
  - They hold until irq_clr.
  - irq_clr zeroes them, but an accepted head in the same cycle as irq_clr is captured.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset, DRAIN, N_VIRT_CHN=2 -> recv_ready=2'b00 during reset and 2'b11 one cycle after release; irq=0; drop_cnt=0.
2. VC1: HEAD, BODY, BODY, TAIL -> drop_cnt[VC1]=4, VC0 count=0, err_proto=0, irq=1 from the cycle after the HEAD.
3. VC0: a TAIL flit from IDLE -> err_proto=2'b01, drop_cnt[VC0]=1; then irq_clr -> all status 0 next cycle.
4. CNT_WIDTH=4, 20 HEAD_TAIL flits on VC0 -> drop_cnt[VC0]=15 (saturated); no err_proto.
5. irq_clr in the same cycle as an accepted VC0 flit -> next cycle drop_cnt[VC0]=1, irq=1.
6. SINK_MODE=0, recv_valid held at 1 for 10 cycles -> recv_ready=0, irq=0, counters 0, send_valid=0 throughout.
7. With HDR_CAP_EN: HEAD 0x0_0000_1234 on VC1, then HEAD 0x0_0000_5678 on VC0 -> first_hdr=0x0_0000_1234, first_hdr_vc=1.
